// File: rtl/mem_req_arbiter_if.sv
// Requester-side and mmu-side request/response bundles
// for the two-port memory request arbiter.
interface req_port_if #(
  parameter int MEM_W = 32
);
  logic               req;
  logic [31:0]        addr;
  logic               we;
  logic [MEM_W/8-1:0] be;
  logic [MEM_W-1:0]   wdata;
  logic               gnt;
  logic               rvalid;
  logic               err;
  logic [MEM_W-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

interface mmu_port_if #(
  parameter int MEM_W = 32
);
  logic               req;
  logic [31:0]        addr;
  logic               we;
  logic [MEM_W/8-1:0] be;
  logic [MEM_W-1:0]   wdata;
  logic               rvalid;
  logic               err;
  logic [MEM_W-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  rvalid, err, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output rvalid, err, rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of scalar and vector memory ports onto
// the single mmu request port, one transaction in flight.
module mem_req_arbiter #(
  parameter int MEM_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  req_port_if.slave  p0,
  req_port_if.slave  p1,
  mmu_port_if.master mmu,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int BE_W = MEM_W / 8;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int TW =
    WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [31:0]      addr;
    logic             we;
    logic [BE_W-1:0]  be;
    logic [MEM_W-1:0] wdata;
  } hold_t;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;
  hold_t           hold_q, hold_d;

  logic in_wait;
  logic resp;
  logic fire;
  logic done;
  logic take;
  logic win;

  assign in_wait = (state_q == S_WAIT);
  assign resp    = mmu.rvalid | mmu.err;
  assign fire    = WD_EN && in_wait && !resp
                   && (timer_q == T_LAST);
  assign done    = in_wait & (resp | fire);
  // Gated by rst so grants stay low while reset is held.
  assign take    = (state_q == S_IDLE)
                   & (p0.req | p1.req) & rst;
  assign win     = (p0.req & p1.req) ? ~last_q : p1.req;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    if (take) begin
      state_d = S_WAIT;
      owner_d = win;
      last_d  = win;
      timer_d = '0;
      if (win) begin
        hold_d = '{p1.addr, p1.we, p1.be, p1.wdata};
      end else begin
        hold_d = '{p0.addr, p0.we, p0.be, p0.wdata};
      end
    end else if (done) begin
      state_d = S_IDLE;
    end else if (in_wait && timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
    end
  end

  assign p0.gnt = take & ~win;
  assign p1.gnt = take & win;

  assign p0.rvalid = in_wait & ~owner_q & mmu.rvalid;
  assign p1.rvalid = in_wait & owner_q & mmu.rvalid;

  assign p0.err = in_wait & ~owner_q & (mmu.err | fire);
  assign p1.err = in_wait & owner_q & (mmu.err | fire);

  assign p0.rdata = (in_wait & ~owner_q & resp)
                    ? mmu.rdata : '0;
  assign p1.rdata = (in_wait & owner_q & resp)
                    ? mmu.rdata : '0;

  assign mmu.req   = in_wait;
  assign mmu.addr  = in_wait ? hold_q.addr : '0;
  assign mmu.we    = in_wait & hold_q.we;
  assign mmu.be    = in_wait ? hold_q.be : '0;
  assign mmu.wdata = in_wait ? hold_q.wdata : '0;

  assign busy_o    = in_wait;
  assign timeout_o = fire;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: vector table, corner sequences,
// then random traffic against a transaction-level model.
module tb_mem_req_arbiter;

  localparam int TMO = 8;

  typedef struct packed {
    logic        rst, r0, r1;
    logic [31:0] a0, a1;
    logic        w0, w1;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
    logic        mv, me;
    logic [31:0] md;
  } in_t;

  typedef struct packed {
    logic        g0, g1, v0, v1, e0, e1;
    logic [31:0] d0, d1;
    logic        mreq;
    logic [31:0] maddr;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    logic        busy, to;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, timeout;

  req_port_if #(.MEM_W(32)) p0_if ();
  req_port_if #(.MEM_W(32)) p1_if ();
  mmu_port_if #(.MEM_W(32)) mmu_if ();

  mem_req_arbiter #(
    .MEM_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p0(p0_if),
    .p1(p1_if),
    .mmu(mmu_if),
    .busy_o(busy),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic in_t mk_in(
    logic rs, logic r0, logic r1,
    logic [31:0] a0, logic [31:0] a1,
    logic mv, logic me, logic [31:0] md);
    in_t x;
    x.rst = rs; x.r0 = r0; x.r1 = r1;
    x.a0 = a0; x.a1 = a1;
    x.w0 = 1'b0; x.be0 = 4'hF; x.wd0 = 32'h0;
    x.w1 = 1'b1; x.be1 = 4'hF; x.wd1 = 32'h12345678;
    x.mv = mv; x.me = me; x.md = md;
    return x;
  endfunction

  function automatic out_t mk_out(
    logic g0, logic g1, logic v0, logic v1,
    logic e0, logic e1,
    logic [31:0] d0, logic [31:0] d1,
    logic mreq, logic [31:0] maddr,
    logic mwe, logic [31:0] mwd,
    logic bsy, logic to);
    out_t o;
    o.g0 = g0; o.g1 = g1; o.v0 = v0; o.v1 = v1;
    o.e0 = e0; o.e1 = e1; o.d0 = d0; o.d1 = d1;
    o.mreq = mreq; o.maddr = maddr; o.mwe = mwe;
    o.mbe = mreq ? 4'hF : 4'h0;
    o.mwd = mwd; o.busy = bsy; o.to = to;
    return o;
  endfunction

  function automatic out_t o_zero();
    return '0;
  endfunction

  function automatic out_t o_wait(
    logic [31:0] a, logic we, logic [31:0] wd);
    return mk_out(0, 0, 0, 0, 0, 0, 0, 0,
                  1, a, we, wd, 1, 0);
  endfunction

  task automatic drive(in_t x);
    rst            = x.rst;
    p0_if.req      = x.r0;
    p0_if.addr     = x.a0;
    p0_if.we       = x.w0;
    p0_if.be       = x.be0;
    p0_if.wdata    = x.wd0;
    p1_if.req      = x.r1;
    p1_if.addr     = x.a1;
    p1_if.we       = x.w1;
    p1_if.be       = x.be1;
    p1_if.wdata    = x.wd1;
    mmu_if.rvalid  = x.mv;
    mmu_if.err     = x.me;
    mmu_if.rdata   = x.md;
  endtask

  function automatic out_t sample();
    out_t o;
    o.g0 = p0_if.gnt;       o.g1 = p1_if.gnt;
    o.v0 = p0_if.rvalid;    o.v1 = p1_if.rvalid;
    o.e0 = p0_if.err;       o.e1 = p1_if.err;
    o.d0 = p0_if.rdata;     o.d1 = p1_if.rdata;
    o.mreq = mmu_if.req;    o.maddr = mmu_if.addr;
    o.mwe = mmu_if.we;      o.mbe = mmu_if.be;
    o.mwd = mmu_if.wdata;
    o.busy = busy;          o.to = timeout;
    return o;
  endfunction

  task automatic chk(string tag, string f,
                     logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h", tag, f, a, e);
    end
  endtask

  task automatic check_out(string tag, out_t e);
    out_t a;
    a = sample();
    chk(tag, "gnt0",   32'(a.g0),   32'(e.g0));
    chk(tag, "gnt1",   32'(a.g1),   32'(e.g1));
    chk(tag, "rv0",    32'(a.v0),   32'(e.v0));
    chk(tag, "rv1",    32'(a.v1),   32'(e.v1));
    chk(tag, "err0",   32'(a.e0),   32'(e.e0));
    chk(tag, "err1",   32'(a.e1),   32'(e.e1));
    chk(tag, "rdata0", a.d0,        e.d0);
    chk(tag, "rdata1", a.d1,        e.d1);
    chk(tag, "mreq",   32'(a.mreq), 32'(e.mreq));
    chk(tag, "maddr",  a.maddr,     e.maddr);
    chk(tag, "mwe",    32'(a.mwe),  32'(e.mwe));
    chk(tag, "mbe",    32'(a.mbe),  32'(e.mbe));
    chk(tag, "mwdata", a.mwd,       e.mwd);
    chk(tag, "busy",   32'(a.busy), 32'(e.busy));
    chk(tag, "tmo",    32'(a.to),   32'(e.to));
  endtask

  task automatic step(string tag, in_t x, out_t e);
    drive(x);
    @(negedge clk);
    check_out(tag, e);
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one pending transaction,
  // round-robin owner, count of WAIT cycles elapsed.
  bit          m_busy, m_own, m_last;
  int          m_cnt;
  logic [31:0] m_addr, m_wd;
  logic        m_we;
  logic [3:0]  m_be;

  function automatic bit m_winner(in_t x);
    if (x.r0 && x.r1) return !m_last;
    return x.r1;
  endfunction

  function automatic out_t model_out(in_t x);
    out_t o;
    bit resp, late;
    o = '0;
    if (!x.rst) return o;
    if (!m_busy) begin
      if (x.r0 || x.r1) begin
        if (m_winner(x)) o.g1 = 1'b1;
        else o.g0 = 1'b1;
      end
    end else begin
      o.busy = 1'b1;  o.mreq = 1'b1;
      o.maddr = m_addr; o.mwe = m_we;
      o.mbe = m_be;   o.mwd = m_wd;
      resp = x.mv || x.me;
      late = !resp && (m_cnt + 1 == TMO);
      if (resp || late) begin
        if (!m_own) begin
          o.v0 = x.mv; o.e0 = x.me || late;
          o.d0 = resp ? x.md : 32'h0;
        end else begin
          o.v1 = x.mv; o.e1 = x.me || late;
          o.d1 = resp ? x.md : 32'h0;
        end
        o.to = late;
      end
    end
    return o;
  endfunction

  task automatic model_step(in_t x);
    bit resp, late, w;
    if (!x.rst) begin
      m_busy = 0; m_last = 1; m_own = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (x.r0 || x.r1) begin
        w = m_winner(x);
        m_own = w; m_last = w; m_busy = 1; m_cnt = 0;
        m_addr = w ? x.a1 : x.a0;
        m_we   = w ? x.w1 : x.w0;
        m_be   = w ? x.be1 : x.be0;
        m_wd   = w ? x.wd1 : x.wd0;
      end
    end else begin
      resp = x.mv || x.me;
      late = !resp && (m_cnt + 1 == TMO);
      if (resp || late) m_busy = 0;
      else m_cnt++;
    end
  endtask

  vec_t tbl[21];

  initial begin
    in_t  x;
    out_t e;

    // Reset, p0 read of 0x1004 answered on cycle 3.
    tbl[0]  = '{mk_in(0,0,0,0,0,0,0,0), o_zero()};
    tbl[1]  = '{mk_in(1,1,0,32'h1004,0,0,0,0),
                mk_out(1,0,0,0,0,0,0,0,0,0,0,0,0,0)};
    tbl[2]  = '{mk_in(1,0,0,0,0,0,0,0),
                o_wait(32'h1004, 0, 0)};
    tbl[3]  = tbl[2];
    tbl[4]  = '{mk_in(1,0,0,0,0,1,0,32'hDEADBEEF),
                mk_out(0,0,1,0,0,0,32'hDEADBEEF,0,
                       1,32'h1004,0,0,1,0)};
    tbl[5]  = '{mk_in(1,0,0,0,0,0,0,0), o_zero()};
    // Fresh reset, then both ports hold requests.
    tbl[6]  = '{mk_in(0,0,0,0,0,0,0,0), o_zero()};
    tbl[7]  = '{mk_in(1,1,1,32'h2000,32'h3000,0,0,0),
                mk_out(1,0,0,0,0,0,0,0,0,0,0,0,0,0)};
    tbl[8]  = '{mk_in(1,1,1,32'h2000,32'h3000,0,0,0),
                o_wait(32'h2000, 0, 0)};
    tbl[9]  = '{mk_in(1,1,1,32'h2000,32'h3000,1,0,32'h11),
                mk_out(0,0,1,0,0,0,32'h11,0,
                       1,32'h2000,0,0,1,0)};
    tbl[10] = '{mk_in(1,1,1,32'h2000,32'h3000,0,0,0),
                mk_out(0,1,0,0,0,0,0,0,0,0,0,0,0,0)};
    tbl[11] = '{mk_in(1,1,1,32'h2000,32'h3000,0,0,0),
                o_wait(32'h3000, 1, 32'h12345678)};
    tbl[12] = '{mk_in(1,1,1,32'h2000,32'h3000,1,0,32'h22),
                mk_out(0,0,0,1,0,0,0,32'h22,
                       1,32'h3000,1,32'h12345678,1,0)};
    tbl[13] = tbl[7];
    tbl[14] = tbl[8];
    tbl[15] = '{mk_in(1,1,1,32'h2000,32'h3000,1,0,32'h33),
                mk_out(0,0,1,0,0,0,32'h33,0,
                       1,32'h2000,0,0,1,0)};
    // p1 write to 0x1010; address changes after the grant.
    tbl[16] = '{mk_in(1,1,1,32'h2000,32'h1010,0,0,0),
                mk_out(0,1,0,0,0,0,0,0,0,0,0,0,0,0)};
    tbl[17] = '{mk_in(1,0,1,32'h2000,32'hBAD0,0,0,0),
                o_wait(32'h1010, 1, 32'h12345678)};
    tbl[18] = tbl[17];
    tbl[19] = '{mk_in(1,0,0,0,32'hBAD0,1,0,0),
                mk_out(0,0,0,1,0,0,0,0,
                       1,32'h1010,1,32'h12345678,1,0)};
    tbl[20] = '{mk_in(1,0,0,0,0,0,0,0), o_zero()};

    drive(mk_in(0,0,0,0,0,0,0,0));
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), tbl[i].i, tbl[i].o);
    end

    // Watchdog fires on the 8th silent WAIT cycle.
    step("to_gnt", mk_in(1,1,0,32'h40,0,0,0,0),
         mk_out(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int k = 1; k < TMO; k++) begin
      step($sformatf("to_w%0d", k),
           mk_in(1,0,0,0,0,0,0,0), o_wait(32'h40, 0, 0));
    end
    step("to_fire", mk_in(1,0,0,0,0,0,0,0),
         mk_out(0,0,0,0,1,0,0,0,1,32'h40,0,0,1,1));
    step("to_idle", mk_in(1,0,0,0,0,0,0,0), o_zero());

    // Response arriving in the watchdog cycle wins.
    step("tr_gnt", mk_in(1,1,0,32'h44,0,0,0,0),
         mk_out(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int k = 1; k < TMO; k++) begin
      step($sformatf("tr_w%0d", k),
           mk_in(1,0,0,0,0,0,0,0), o_wait(32'h44, 0, 0));
    end
    step("tr_resp", mk_in(1,0,0,0,0,1,0,32'h55),
         mk_out(0,0,1,0,0,0,32'h55,0,1,32'h44,0,0,1,0));

    // mmu error, then reset in the middle of WAIT.
    step("er_gnt", mk_in(1,1,0,32'h50,0,0,0,0),
         mk_out(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("er_w1", mk_in(1,0,0,0,0,0,0,0),
         o_wait(32'h50, 0, 0));
    step("er_resp", mk_in(1,0,0,0,0,0,1,0),
         mk_out(0,0,0,0,1,0,0,0,1,32'h50,0,0,1,0));
    step("rs_gnt", mk_in(1,0,1,0,32'h60,0,0,0),
         mk_out(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    step("rs_w1", mk_in(1,0,0,0,0,0,0,0),
         o_wait(32'h60, 1, 32'h12345678));
    step("rs_w2", mk_in(1,0,0,0,0,0,0,0),
         o_wait(32'h60, 1, 32'h12345678));
    step("rs_async", mk_in(0,0,0,0,0,0,0,0), o_zero());
    for (int k = 0; k < 3; k++) begin
      step($sformatf("rs_after%0d", k),
           mk_in(1,0,0,0,0,1,0,32'h77), o_zero());
    end

    // Random traffic against the reference model.
    m_busy = 0; m_last = 1; m_own = 0; m_cnt = 0;
    m_addr = 0; m_we = 0; m_be = 0; m_wd = 0;
    for (int n = 0; n < 3000; n++) begin
      x.rst = ($urandom_range(0, 299) != 0);
      x.r0  = 1'($urandom);
      x.r1  = 1'($urandom);
      x.a0  = $urandom;  x.a1  = $urandom;
      x.w0  = 1'($urandom); x.w1 = 1'($urandom);
      x.be0 = 4'($urandom); x.be1 = 4'($urandom);
      x.wd0 = $urandom;  x.wd1 = $urandom;
      x.mv  = ($urandom_range(0, 4) == 0);
      x.me  = ($urandom_range(0, 9) == 0);
      x.md  = $urandom;
      e = model_out(x);
      step($sformatf("rnd%0d", n), x, e);
      model_step(x);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
